// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered RISC-V immediate generator with a two-entry
// (output + skid) buffer on a valid/ready handshake. Unsupported format
// selects are flagged per beat and counted, saturating, on acceptance.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_ext,
  output logic [TAG_W-1:0] out_tag,
  output logic             illegal,
  output logic [CNT_W-1:0] err_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             ill;
  } beat_t;

  beat_t           dec;
  beat_t           or_q, sk_q;
  logic            or_v, sk_v;
  logic [CNT_W-1:0] cnt_q;
  logic            accept, deliver;
  logic            unused_opcode;

  // Opcode field is not part of any immediate.
  assign unused_opcode = ^instr[6:0];

  // Combinational format decode on the input side.
  always_comb begin
    dec     = '0;
    dec.tag = in_tag;
    unique case (imm_src)
      3'b000: dec.imm = XLEN'($signed(instr[31:20]));
      3'b001: dec.imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      3'b010: dec.imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                       instr[11:8], 1'b0}));
      3'b011: dec.imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                       instr[30:21], 1'b0}));
      3'b100: dec.imm = XLEN'($signed({instr[31:12], 12'b0}));
      3'b101: dec.imm = XLEN'(instr[19:15]);
      3'b110: begin
        // RV64 shifts use a 6-bit shamt, RV32 only 5 bits.
        if (XLEN == 64) dec.imm = XLEN'(instr[25:20]);
        else            dec.imm = XLEN'(instr[24:20]);
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // Ready depends only on skid occupancy and reset, never on out_ready.
  assign in_ready = ~sk_v & ~rst;
  assign accept   = in_valid & in_ready;
  assign deliver  = or_v & out_ready;

  // Output/skid register pair: skid refills OR on delivery, new beats
  // land in OR when it is free or draining, otherwise in SK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      or_q <= '0;
      or_v <= 1'b0;
      sk_q <= '0;
      sk_v <= 1'b0;
    end else if (deliver) begin
      if (sk_v) begin
        or_q <= sk_q;
        sk_v <= 1'b0;
      end else if (accept) begin
        or_q <= dec;
      end else begin
        or_v <= 1'b0;
      end
    end else if (accept) begin
      if (!or_v) begin
        or_q <= dec;
        or_v <= 1'b1;
      end else begin
        sk_q <= dec;
        sk_v <= 1'b1;
      end
    end
  end

  // Saturating count of illegal formats, taken at acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   cnt_q <= '0;
    else if (accept && dec.ill && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  assign out_valid = or_v;
  assign imm_ext   = or_q.imm;
  assign out_tag   = or_q.tag;
  assign illegal   = or_q.ill;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: one RV32 instance (2-bit error counter)
// and one RV64 instance sharing clock and reset.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RV32 instance
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1;
  logic [31:0] a_instr = '0;
  logic [2:0]  a_src = '0;
  logic [7:0]  a_in_tag = '0, a_out_tag;
  logic [31:0] a_imm;
  logic        a_ill;
  logic [1:0]  a_cnt;

  // RV64 instance
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1;
  logic [31:0] b_instr = '0;
  logic [2:0]  b_src = '0;
  logic [7:0]  b_in_tag = '0, b_out_tag;
  logic [63:0] b_imm;
  logic        b_ill;
  logic [7:0]  b_cnt;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .CNT_W(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .instr(a_instr), .imm_src(a_src), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .imm_ext(a_imm),
    .out_tag(a_out_tag), .illegal(a_ill), .err_cnt(a_cnt));

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .instr(b_instr), .imm_src(b_src), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .imm_ext(b_imm),
    .out_tag(b_out_tag), .illegal(b_ill), .err_cnt(b_cnt));

  // Offer one beat to the RV32 instance; returns #1 after its acceptance edge.
  task automatic beat_a(input logic [31:0] ins, input logic [2:0] src,
                        input logic [7:0] tag);
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_instr = ins; a_src = src; a_in_tag = tag;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic beat_b(input logic [31:0] ins, input logic [2:0] src,
                        input logic [7:0] tag);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_instr = ins; b_src = src; b_in_tag = tag;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_imm !== 32'h0 || a_out_tag !== 8'h0 ||
        a_ill !== 1'b0 || a_cnt !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b imm=%h tag=%h ill=%b cnt=%0d want all zero",
               a_out_valid, a_imm, a_out_tag, a_ill, a_cnt);
    end
    checks++;
    if (a_in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b want 0", a_in_ready);
    end
    rst = 1'b0; #1;
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_after_reset: got %b/%b want 1/1", a_in_ready, b_in_ready);
    end
  endtask

  task automatic test_decode32;
    logic [31:0] ins [7];
    logic [2:0]  src [7];
    logic [31:0] exp [7];
    ins = '{32'hFFC12083, 32'hFE000CE3, 32'h123452B7, 32'hFE112C23,
            32'h03F00000, 32'h800F8000, 32'hFFDFF06F};
    src = '{3'b000, 3'b010, 3'b100, 3'b001, 3'b110, 3'b101, 3'b011};
    exp = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFFFF8,
            32'h0000001F, 32'h0000001F, 32'hFFFFFFFC};
    a_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      beat_a(ins[i], src[i], 8'(i + 8'h40));
      checks++;
      if (a_out_valid !== 1'b1 || a_imm !== exp[i] || a_ill !== 1'b0 ||
          a_out_tag !== 8'(i + 8'h40)) begin
        errors++;
        $display("FAIL decode32_%0d: got v=%b imm=%h ill=%b tag=%h want v=1 imm=%h ill=0 tag=%h",
                 i, a_out_valid, a_imm, a_ill, a_out_tag, exp[i], 8'(i + 8'h40));
      end
    end
  endtask

  task automatic test_illegal;
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      beat_a(32'hFFFFFFFF, 3'b111, 8'(i));
      checks++;
      if (a_out_valid !== 1'b1 || a_imm !== 32'h0 || a_ill !== 1'b1 ||
          a_cnt !== exp_cnt[i]) begin
        errors++;
        $display("FAIL illegal_%0d: got v=%b imm=%h ill=%b cnt=%0d want v=1 imm=0 ill=1 cnt=%0d",
                 i, a_out_valid, a_imm, a_ill, a_cnt, exp_cnt[i]);
      end
    end
    beat_a(32'h000F8000, 3'b101, 8'h55);
    checks++;
    if (a_imm !== 32'h1F || a_ill !== 1'b0 || a_cnt !== 2'd3) begin
      errors++;
      $display("FAIL csr_imm: got imm=%h ill=%b cnt=%0d want imm=1f ill=0 cnt=3",
               a_imm, a_ill, a_cnt);
    end
  endtask

  task automatic test_decode64;
    logic [31:0] ins [4];
    logic [2:0]  src [4];
    logic [63:0] exp [4];
    ins = '{32'hFFDFF06F, 32'h800002B7, 32'h03F00000, 32'h123452B7};
    src = '{3'b011, 3'b100, 3'b110, 3'b100};
    exp = '{64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_80000000,
            64'h00000000_0000003F, 64'h00000000_12345000};
    for (int i = 0; i < 4; i++) begin
      beat_b(ins[i], src[i], 8'(i));
      checks++;
      if (b_out_valid !== 1'b1 || b_imm !== exp[i] || b_ill !== 1'b0) begin
        errors++;
        $display("FAIL decode64_%0d: got v=%b imm=%h ill=%b want v=1 imm=%h ill=0",
                 i, b_out_valid, b_imm, b_ill, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_src = 3'b000; a_in_tag = 8'd0; a_instr = {12'd0, 20'h0};
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b1 || a_out_tag !== 8'(i) || a_imm !== 32'(i) ||
          a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL burst_%0d: got v=%b tag=%0d imm=%h rdy=%b want v=1 tag=%0d imm=%h rdy=1",
                 i, a_out_valid, a_out_tag, a_imm, a_in_ready, i, 32'(i));
      end
      if (i < 15) begin
        a_in_tag = 8'(i + 1); a_instr = {12'(i + 1), 20'h0};
      end else begin
        a_in_valid = 1'b0;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL burst_drain: got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_backpressure;
    a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_src = 3'b000; a_instr = 32'h00A00000; a_in_tag = 8'hA1;
    @(posedge clk); #1;  // A into OR
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 8'hA1 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_a: got v=%b tag=%h rdy=%b want v=1 tag=a1 rdy=1", a_out_valid, a_out_tag, a_in_ready);
    end
    a_instr = 32'h00B00000; a_in_tag = 8'hB2;
    @(posedge clk); #1;  // B into SK
    checks++;
    if (a_in_ready !== 1'b0 || a_out_tag !== 8'hA1 || a_imm !== 32'h00A) begin
      errors++;
      $display("FAIL bp_b: got rdy=%b tag=%h imm=%h want rdy=0 tag=a1 imm=a", a_in_ready, a_out_tag, a_imm);
    end
    a_instr = 32'h00C00000; a_in_tag = 8'hC3;
    @(posedge clk); #1;  // C offered, refused
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_out_tag !== 8'hA1 || a_imm !== 32'h00A) begin
      errors++;
      $display("FAIL bp_hold: got rdy=%b v=%b tag=%h imm=%h want rdy=0 v=1 tag=a1 imm=a",
               a_in_ready, a_out_valid, a_out_tag, a_imm);
    end
    a_out_ready = 1'b1;
    @(posedge clk); #1;  // A delivered, B moves to OR
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 8'hB2 || a_imm !== 32'h00B || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_deliver_b: got v=%b tag=%h imm=%h rdy=%b want v=1 tag=b2 imm=b rdy=1",
               a_out_valid, a_out_tag, a_imm, a_in_ready);
    end
    @(posedge clk); #1;  // B delivered, C accepted into OR
    a_in_valid = 1'b0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 8'hC3 || a_imm !== 32'h00C) begin
      errors++;
      $display("FAIL bp_deliver_c: got v=%b tag=%h imm=%h want v=1 tag=c3 imm=c", a_out_valid, a_out_tag, a_imm);
    end
    @(posedge clk); #1;  // C delivered
    checks++;
    if (a_out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain: got v=%b want 0", a_out_valid);
    end
  endtask

  task automatic test_reset_mid_stall;
    a_out_ready = 1'b0;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_src = 3'b000; a_instr = 32'h00D00000; a_in_tag = 8'hD4;
    @(posedge clk); #1;
    a_in_tag = 8'hE5;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_cnt !== 2'd3) begin
      errors++;
      $display("FAIL stall_full: got rdy=%b v=%b cnt=%0d want rdy=0 v=1 cnt=3", a_in_ready, a_out_valid, a_cnt);
    end
    rst = 1'b1; #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_cnt !== 2'd0 || a_in_ready !== 1'b0 || a_out_tag !== 8'h0) begin
      errors++;
      $display("FAIL mid_reset: got v=%b cnt=%0d rdy=%b tag=%h want v=0 cnt=0 rdy=0 tag=0",
               a_out_valid, a_cnt, a_in_ready, a_out_tag);
    end
    @(posedge clk); #1;
    rst = 1'b0; a_out_ready = 1'b1; #1;
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++; $display("FAIL ready_post_reset: got %b want 1", a_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (a_out_valid !== 1'b0) begin
        errors++; $display("FAIL stale_beat_%0d: got v=%b tag=%h want v=0", i, a_out_valid, a_out_tag);
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_illegal();
    test_decode64();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Parametrised, registered immediate generator for the decode stage of the RISC-V core. It accepts a raw 32-bit instruction word plus an immediate-format select over a valid/ready handshake. It produces the sign- or zero-extended immediate at XLEN width one cycle later, with a carried tag. A 2-entry skid buffer gives full throughput under backpressure. The block also flags unsupported format selects and counts them.

Parameters:
XLEN, 32, output datapath width; legal values 32 or 64.
TAG_W, 8, width of the sideband tag (PC index / rd) passed through unchanged.
CNT_W, 8, width of the saturating illegal-format counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat.
instr  in  32  raw instruction word.
imm_src  in  3  immediate format select.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  output beat valid.
out_ready  in  1  downstream accepts the beat.
imm_ext  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag paired with imm_ext.
illegal  out  1  the beat carried an unsupported imm_src.
err_cnt  out  CNT_W  saturating count of accepted illegal beats.

Behaviour:
- Format decode (sx = sign-extend to XLEN, zx = zero-extend to XLEN):
  - 000 I: sx(instr[31:20]).
  - 001 S: sx({instr[31:25],instr[11:7]}).
  - 010 B: sx({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 J: sx({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 100 U: sx({instr[31:12],12'b0}). This is identical to the raw value at XLEN=32 and sign-extended at XLEN=64.
  - 101 Z (CSR immediate): zx(instr[19:15]).
  - 110 SH (shift amount): zx(instr[25:20]) when XLEN=64; zx(instr[24:20]) when XLEN=32.
  - 111: imm_ext = 0, illegal = 1.
  - illegal = 0 for every other code.
- Handshake:
  - A beat is accepted when in_valid & in_ready.
  - A beat is delivered when out_valid & out_ready.
  - Decode is combinational on the input side. Results are registered, so latency is exactly 1 cycle from acceptance to out_valid when the output register is empty or draining.
- Storage is an output register (OR) plus a skid register (SK).
  - On accept: the beat goes to OR if OR is empty or delivering this cycle. Otherwise it goes to SK.
  - On delivery with SK full: SK moves to OR in the same cycle, and SK empties.
  - in_ready = ~SK_valid & ~rst. It depends only on state and reset, never combinationally on out_ready.
  - Throughput is 1 beat/cycle with out_ready held high.
  - Beat order is strictly preserved; no beat is dropped or duplicated.
- While out_valid = 1 and out_ready = 0: imm_ext, out_tag and illegal hold stable.
- When in_valid = 0, instr, imm_src and in_tag are don't-care and no state changes.
- err_cnt increments by 1 on each accepted beat with imm_src = 111. It saturates at 2^CNT_W - 1. It counts on acceptance, not delivery.
- Reset (asynchronous assert; deassert is synchronised externally):
  - out_valid = 0, imm_ext = 0, out_tag = 0, illegal = 0, err_cnt = 0.
  - SK is emptied and in_ready = 0 while rst is high.
  - A reset mid-transfer discards any OR/SK contents. After deassert, in_ready = 1 on the first cycle.

Test Plan:
- XLEN=32, out_ready=1: instr 0xFFC12083 with src 000 -> imm_ext 0xFFFFFFFC one cycle after accept.
  - Then 0xFE000CE3 with src 010 -> 0xFFFFFFF8.
  - Then 0x123452B7 with src 100 -> 0x12345000.
- XLEN=64: instr 0xFFDFF06F with src 011 -> 0xFFFFFFFF_FFFFFFFC. Then 0x800002B7 with src 100 -> 0xFFFFFFFF_80000000.
- Back-to-back burst, 16 beats, out_ready=1, tags 0..15 -> in_ready stays 1, out_valid is high for 16 consecutive cycles, tags emerge 0..15 in order.
- Backpressure, out_ready=0: accept tag A (goes to OR) and tag B (goes to SK) -> in_ready=0 the cycle after B, and a tag C offered is not accepted.
  - Raise out_ready -> A, B, C are delivered in order, and imm_ext holds stable while stalled.
- Illegal formats, CNT_W=2: send five beats with src 111 -> each outputs imm_ext 0 and illegal 1; err_cnt goes 1, 2, 3, 3, 3.
  - src 101 with instr[19:15]=5'h1F -> imm_ext 0x1F, illegal 0.
- Reset mid-stall: with OR and SK full, assert rst for 1 cycle -> out_valid 0, err_cnt 0, in_ready 0 during rst and 1 on the first cycle after deassert; no stale beat is delivered.
